ip2mac_cache: RTL and testbench
===============================

// Module: ip2mac_cache
// PURPOSE
//  Parametrised IP->MAC resolution cache (ARP table) for the TOE transmit path.
//  Holds DEPTH entries and updates them from received ARP replies.
//  Ages entries out on an external tick, evicts the oldest entry when full,
//  and serves lookups through a req/ready/done handshake using a sequential scan.
// PARAMETERS
//  IP_W     32  IP address width
//  MAC_W    48  MAC address width
//  DEPTH    8   number of entries (power of 2, >=2)
//  AGE_W    8   age counter width
//  AGE_MAX  200 age at which an entry expires (1..2^AGE_W-1)
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous reset, active-low
//  lookup_req   in   1        lookup request, sampled when lookup_ready=1
//  lookup_ip    in   IP_W     address to resolve, captured on accept
//  lookup_ready out  1        FSM idle, can accept a request
//  lookup_done  out  1        one-cycle pulse, result valid
//  lookup_found out  1        hit flag, held until next done
//  lookup_mac   out  MAC_W    resolved MAC, held until next done (0 on miss)
//  wr_en        in   1        insert/update strobe
//  wr_ip        in   IP_W     IP to insert
//  wr_mac       in   MAC_W    MAC to insert
//  tick         in   1        aging pulse, one cycle wide
//  flush        in   1        invalidate all entries
//  entry_count  out  $clog2(DEPTH+1)  number of valid entries
// BEHAVIOUR
//  Reset (reset=0, async): all entries invalid, ages 0; lookup_ready=1, done=0,
//    found=0, mac=0, entry_count=0; FSM->IDLE. Reset mid-scan aborts with no done.
//  Lookup FSM IDLE/SCAN/DONE:
//   IDLE: ready=1; if req, capture ip, idx=0, go SCAN (accept edge E0).
//   SCAN: ready=0; compare entry[idx] (valid && ip match) each cycle.
//     Hit at idx k: found=1, mac=entry MAC, go DONE at edge E(k+1).
//     idx=DEPTH-1 miss: found=0, mac=0, go DONE at edge E(DEPTH).
//   DONE: done=1 for exactly one cycle, ready=0; next edge -> IDLE.
//   Latency: hit at k -> done visible after E(k+1); miss -> after E(DEPTH).
//   Special: lookup_ip==all-ones -> found=1, mac=all-ones, DONE at E1 (broadcast).
//     lookup_ip==0 -> scanned normally; it always misses (0 is never stored).
//   A scan compares table contents as registered before the compare edge;
//     writes, ticks and flush during a scan affect later compares only.
//  Write (1 cycle, always accepted, wr_ip==0 or all-ones ignored):
//   - ip present in a valid entry: overwrite MAC, age=0 (no count change).
//   - else lowest-index invalid entry: fill, valid=1, age=0, count+1.
//   - else full: replace entry with highest age (tie -> lowest index), age=0.
//  Aging: on tick, every valid entry age+1; an entry whose age reaches AGE_MAX
//    goes invalid at that edge, and count drops accordingly.
//  Simultaneous events, priority flush > write > tick:
//   - flush+wr_en: table cleared, write dropped.
//   - wr_en+tick: written entry age=0; other entries age normally.
//   - tick expiry + write fill in one cycle: count = old - expired + new.
//   - flush: all invalid, count=0 next cycle; in-flight lookup misses on the
//     remaining compares.
//  entry_count is registered and equals popcount(valid) at all times.
// TESTING
//  1. Write 0a.d6.80.ea->9c:eb:e8:22:fd:18, then look it up -> done after E1,
//     found=1, mac=9ceb_e822_fd18, count=1.
//  2. Fill 8 IPs, look up 10.0.0.99 -> done after E8, found=0, mac=0.
//     Look up the entry at index 5 -> done after E6.
//  3. Full table, age entry3 via ticks (rewrite the others), write a new IP ->
//     it lands in idx3, count stays 8.
//  4. Write, then AGE_MAX ticks -> entry invalid, count=0, lookup misses.
//     Rewrite of the same IP at the AGE_MAX-1 tick -> age=0, stays valid.
//  5. Rewrite an existing IP with a new MAC -> same index, count unchanged,
//     lookup returns the new MAC.
//  6. Pull reset low mid-scan -> no done, ready=1; flush+wr_en together ->
//     count=0; lookup ff.ff.ff.ff -> found=1 after E1.

Source files
------------

// File: rtl/ip2mac_cache.sv
// IP->MAC resolution cache: DEPTH entries, tick-driven aging, oldest-entry eviction when full.
// Lookup scans one entry per cycle (hit at k: done after k+1 edges, miss: DEPTH); writes always accepted.
module ip2mac_cache #(
  parameter int IP_W    = 32,
  parameter int MAC_W   = 48,
  parameter int DEPTH   = 8,
  parameter int AGE_W   = 8,
  parameter int AGE_MAX = 200,
  localparam int IW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_req,
  input  logic [IP_W-1:0]  lookup_ip,
  output logic             lookup_ready,
  output logic             lookup_done,
  output logic             lookup_found,
  output logic [MAC_W-1:0] lookup_mac,
  input  logic             wr_en,
  input  logic [IP_W-1:0]  wr_ip,
  input  logic [MAC_W-1:0] wr_mac,
  input  logic             tick,
  input  logic             flush,
  output logic [CW-1:0]    entry_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IP_W-1:0]    lkip_q, lkip_d;
  logic               found_q, found_d;
  logic [MAC_W-1:0]   mac_q, mac_d;
  logic [CW-1:0]      count_q, count_d;

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [IP_W-1:0]    tip_q  [DEPTH];
  logic [IP_W-1:0]    tip_d  [DEPTH];
  logic [MAC_W-1:0]   tmac_q [DEPTH];
  logic [MAC_W-1:0]   tmac_d [DEPTH];
  logic [AGE_W-1:0]   age_q  [DEPTH];
  logic [AGE_W-1:0]   age_d  [DEPTH];

  logic               wr_ok, hit, free;
  logic [IW-1:0]      hit_idx, free_idx, old_idx, tgt;
  logic [AGE_W-1:0]   old_age;

  // Zero and broadcast are reserved and never enter the table.
  assign wr_ok = wr_en && (wr_ip != '0) && (wr_ip != '1);

  always_comb begin
    vld_d    = vld_q;
    tip_d    = tip_q;
    tmac_d   = tmac_q;
    age_d    = age_q;
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (tip_q[i] == wr_ip) && !hit) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!vld_q[i] && !free) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
      // Strict compare keeps the lowest index on age ties.
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IW'(i);
      end
    end
    tgt = hit ? hit_idx : (free ? free_idx : old_idx);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_d[i] = 1'b0;
        age_d[i] = '0;
      end
    end else begin
      if (tick) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i]) begin
            age_d[i] = age_q[i] + AGE_W'(1);
            if (age_q[i] + AGE_W'(1) == AGE_W'(AGE_MAX)) vld_d[i] = 1'b0;
          end
        end
      end
      // The write lands after aging so a refreshed entry survives an expiring tick.
      if (wr_ok) begin
        vld_d[tgt]  = 1'b1;
        tip_d[tgt]  = wr_ip;
        tmac_d[tgt] = wr_mac;
        age_d[tgt]  = '0;
      end
    end

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(vld_d[i]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lkip_d  = lkip_q;
    found_d = found_q;
    mac_d   = mac_q;
    case (state_q)
      S_IDLE: begin
        if (lookup_req) begin
          lkip_d  = lookup_ip;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (lkip_q == '1) begin
          found_d = 1'b1;
          mac_d   = '1;
          state_d = S_DONE;
        end else if (vld_q[idx_q] && (tip_q[idx_q] == lkip_q)) begin
          found_d = 1'b1;
          mac_d   = tmac_q[idx_q];
          state_d = S_DONE;
        end else if (idx_q == IW'(DEPTH - 1)) begin
          found_d = 1'b0;
          mac_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lkip_q  <= '0;
      found_q <= 1'b0;
      mac_q   <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tip_q[i]  <= '0;
        tmac_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lkip_q  <= lkip_d;
      found_q <= found_d;
      mac_q   <= mac_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      tip_q   <= tip_d;
      tmac_q  <= tmac_d;
      age_q   <= age_d;
    end
  end

  assign lookup_ready = (state_q == S_IDLE);
  assign lookup_done  = (state_q == S_DONE);
  assign lookup_found = found_q;
  assign lookup_mac   = mac_q;
  assign entry_count  = count_q;

endmodule

// File: tb/tb_ip2mac_cache.sv
// Directed bench for ip2mac_cache: inputs driven and outputs sampled on the falling edge.
module tb_ip2mac_cache;
  localparam int IP_W = 32;
  localparam int MAC_W = 48;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             lookup_req;
  logic [IP_W-1:0]  lookup_ip;
  logic             lookup_ready;
  logic             lookup_done;
  logic             lookup_found;
  logic [MAC_W-1:0] lookup_mac;
  logic             wr_en;
  logic [IP_W-1:0]  wr_ip;
  logic [MAC_W-1:0] wr_mac;
  logic             tick;
  logic             flush;
  logic [CW-1:0]    entry_count;

  int nchk = 0;
  int nfail = 0;
  int lk_lat;
  logic lk_found;
  logic [MAC_W-1:0] lk_mac;

  always #5 clk = ~clk;

  ip2mac_cache #(.IP_W(32), .MAC_W(48), .DEPTH(8), .AGE_W(8), .AGE_MAX(200)) dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_ready(lookup_ready),
    .lookup_done(lookup_done), .lookup_found(lookup_found), .lookup_mac(lookup_mac),
    .wr_en(wr_en), .wr_ip(wr_ip), .wr_mac(wr_mac),
    .tick(tick), .flush(flush), .entry_count(entry_count)
  );

  task automatic wr(input logic [31:0] ip, input logic [47:0] mac,
                    input logic tk = 1'b0, input logic fl = 1'b0);
    wr_en = 1'b1; wr_ip = ip; wr_mac = mac; tick = tk; flush = fl;
    @(negedge clk);
    wr_en = 1'b0; tick = 1'b0; flush = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  // lk_lat counts edges after the accept edge; -1 means the bound expired.
  task automatic lookup(input logic [31:0] ip);
    lk_lat = -1; lk_found = 1'b0; lk_mac = '0;
    lookup_req = 1'b1; lookup_ip = ip;
    @(negedge clk);
    lookup_req = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (lookup_done) begin
        lk_lat = n; lk_found = lookup_found; lk_mac = lookup_mac;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    nchk++; if (lookup_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready got %b exp 1", lookup_ready); end
    nchk++; if (lookup_done !== 1'b0) begin nfail++; $display("FAIL rst_done got %b exp 0", lookup_done); end
    nchk++; if (lookup_found !== 1'b0) begin nfail++; $display("FAIL rst_found got %b exp 0", lookup_found); end
    nchk++; if (lookup_mac !== 48'h0) begin nfail++; $display("FAIL rst_mac got %h exp 0", lookup_mac); end
    nchk++; if (entry_count !== 4'd0) begin nfail++; $display("FAIL rst_count got %0d exp 0", entry_count); end
  endtask

  task automatic test_write_lookup;
    wr(32'h0ad6_80ea, 48'h9ceb_e822_fd18);
    nchk++; if (entry_count !== 4'd1) begin nfail++; $display("FAIL wl_count got %0d exp 1", entry_count); end
    lookup(32'h0ad6_80ea);
    nchk++; if (lk_lat !== 1) begin nfail++; $display("FAIL wl_lat got %0d exp 1", lk_lat); end
    nchk++; if (lk_found !== 1'b1) begin nfail++; $display("FAIL wl_found got %b exp 1", lk_found); end
    nchk++; if (lk_mac !== 48'h9ceb_e822_fd18) begin nfail++; $display("FAIL wl_mac got %h exp 9cebe822fd18", lk_mac); end
    nchk++; if (lookup_ready !== 1'b1) begin nfail++; $display("FAIL wl_ready got %b exp 1", lookup_ready); end
  endtask

  task automatic test_fill;
    for (int i = 1; i < 8; i++) wr(32'h0a00_0000 + i, 48'h0200_0000_0000 + i);
    nchk++; if (entry_count !== 4'd8) begin nfail++; $display("FAIL fill_count got %0d exp 8", entry_count); end
    lookup(32'h0a00_0063);
    nchk++; if (lk_lat !== 8) begin nfail++; $display("FAIL fill_miss_lat got %0d exp 8", lk_lat); end
    nchk++; if (lk_found !== 1'b0 || lk_mac !== 48'h0) begin nfail++; $display("FAIL fill_miss got found=%b mac=%h exp 0/0", lk_found, lk_mac); end
    lookup(32'h0a00_0005);
    nchk++; if (lk_lat !== 6) begin nfail++; $display("FAIL fill_idx5_lat got %0d exp 6", lk_lat); end
    nchk++; if (lk_mac !== 48'h0200_0000_0005) begin nfail++; $display("FAIL fill_idx5_mac got %h exp 020000000005", lk_mac); end
    lookup(32'h0);
    nchk++; if (lk_lat !== 8 || lk_found !== 1'b0) begin nfail++; $display("FAIL fill_zero got lat=%0d found=%b exp 8/0", lk_lat, lk_found); end
  endtask

  task automatic test_evict;
    ticks(1);
    wr(32'h0ad6_80ea, 48'h9ceb_e822_fd18);
    for (int i = 1; i < 8; i++) if (i != 3) wr(32'h0a00_0000 + i, 48'h0200_0000_0000 + i);
    wr(32'h0a00_0032, 48'h0000_0000_0050);
    nchk++; if (entry_count !== 4'd8) begin nfail++; $display("FAIL ev_count got %0d exp 8", entry_count); end
    lookup(32'h0a00_0032);
    nchk++; if (lk_lat !== 4 || lk_mac !== 48'h50) begin nfail++; $display("FAIL ev_new got lat=%0d mac=%h exp 4/50", lk_lat, lk_mac); end
    lookup(32'h0a00_0003);
    nchk++; if (lk_lat !== 8 || lk_found !== 1'b0) begin nfail++; $display("FAIL ev_old got lat=%0d found=%b exp 8/0", lk_lat, lk_found); end
  endtask

  task automatic test_rewrite;
    wr(32'h0a00_0005, 48'h1234_5678_9abc);
    nchk++; if (entry_count !== 4'd8) begin nfail++; $display("FAIL rw_count got %0d exp 8", entry_count); end
    lookup(32'h0a00_0005);
    nchk++; if (lk_lat !== 6 || lk_mac !== 48'h1234_5678_9abc) begin nfail++; $display("FAIL rw_lookup got lat=%0d mac=%h exp 6/123456789abc", lk_lat, lk_mac); end
  endtask

  task automatic test_aging;
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    nchk++; if (entry_count !== 4'd0) begin nfail++; $display("FAIL ag_flush got %0d exp 0", entry_count); end
    wr(32'h0a00_0101, 48'h0000_0000_00aa);
    ticks(199);
    nchk++; if (entry_count !== 4'd1) begin nfail++; $display("FAIL ag_199 got %0d exp 1", entry_count); end
    ticks(1);
    nchk++; if (entry_count !== 4'd0) begin nfail++; $display("FAIL ag_expire got %0d exp 0", entry_count); end
    lookup(32'h0a00_0101);
    nchk++; if (lk_lat !== 8 || lk_found !== 1'b0) begin nfail++; $display("FAIL ag_miss got lat=%0d found=%b exp 8/0", lk_lat, lk_found); end
    wr(32'h0a00_0101, 48'h0000_0000_00aa);
    ticks(198);
    wr(32'h0a00_0101, 48'h0000_0000_00ab, 1'b1);
    ticks(199);
    nchk++; if (entry_count !== 4'd1) begin nfail++; $display("FAIL ag_refresh got %0d exp 1", entry_count); end
    wr(32'h0a00_0102, 48'h0000_0000_00bb, 1'b1);
    nchk++; if (entry_count !== 4'd1) begin nfail++; $display("FAIL ag_exp_fill got %0d exp 1", entry_count); end
    lookup(32'h0a00_0101);
    nchk++; if (lk_found !== 1'b0) begin nfail++; $display("FAIL ag_a_gone got found=%b exp 0", lk_found); end
    lookup(32'h0a00_0102);
    nchk++; if (lk_lat !== 2 || lk_mac !== 48'hbb) begin nfail++; $display("FAIL ag_b got lat=%0d mac=%h exp 2/bb", lk_lat, lk_mac); end
  endtask

  task automatic test_reset_flush;
    logic saw_done;
    lookup_req = 1'b1; lookup_ip = 32'h0a00_0999;
    @(negedge clk);
    lookup_req = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    nchk++; if (lookup_ready !== 1'b1 || entry_count !== 4'd0) begin nfail++; $display("FAIL mr_state got ready=%b count=%0d exp 1/0", lookup_ready, entry_count); end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      if (lookup_done) saw_done = 1'b1;
    end
    nchk++; if (saw_done !== 1'b0) begin nfail++; $display("FAIL mr_no_done got %b exp 0", saw_done); end
    wr(32'h0a00_0201, 48'h0000_0000_0011);
    nchk++; if (entry_count !== 4'd1) begin nfail++; $display("FAIL fw_pre got %0d exp 1", entry_count); end
    wr(32'h0a00_0202, 48'h0000_0000_0022, 1'b0, 1'b1);
    nchk++; if (entry_count !== 4'd0) begin nfail++; $display("FAIL fw_count got %0d exp 0", entry_count); end
    lookup(32'h0a00_0202);
    nchk++; if (lk_found !== 1'b0 || lk_lat !== 8) begin nfail++; $display("FAIL fw_dropped got found=%b lat=%0d exp 0/8", lk_found, lk_lat); end
    lookup(32'hffff_ffff);
    nchk++; if (lk_lat !== 1 || lk_found !== 1'b1 || lk_mac !== 48'hffff_ffff_ffff) begin nfail++; $display("FAIL bcast got lat=%0d found=%b mac=%h exp 1/1/ffffffffffff", lk_lat, lk_found, lk_mac); end
  endtask

  initial begin
    reset = 1'b0; lookup_req = 1'b0; lookup_ip = '0;
    wr_en = 1'b0; wr_ip = '0; wr_mac = '0; tick = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_write_lookup();
    test_fill();
    test_evict();
    test_rewrite();
    test_aging();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
